// File: rtl/union_byte_sched.sv
// Two-requester word-to-byte serializer: round-robin grants a 16-bit word and
// streams it as two bytes, overlapping the next grant with the final byte.
module union_byte_sched #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [1:0]  req_ready,
    output logic        out_valid,
    output logic [7:0]  out_byte,
    output logic        out_src,
    output logic        out_last,
    input  logic        out_ready,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

    state_t      r_state, w_next;
    logic [15:0] r_word;
    logic        r_owner;
    logic        r_rr;

    logic        w_gidx;
    logic        w_win;
    logic        w_grant;
    logic [15:0] w_slice;

    // req_ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        w_gidx    = (req_valid == 2'b11) ? r_rr : req_valid[1];
        w_win     = rst_n && ((r_state == IDLE) || ((r_state == SECOND) && out_ready));
        w_grant   = w_win && (|req_valid);
        req_ready = 2'b00;
        if (w_grant) req_ready[w_gidx] = 1'b1;
        w_slice   = w_gidx ? req_data[31:16] : req_data[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        out_valid = 1'b0;
        out_last  = 1'b0;
        out_byte  = 8'h00;
        out_src   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) w_next = FIRST;
            end
            FIRST: begin
                out_valid = 1'b1;
                out_src   = r_owner;
                out_byte  = LOW_FIRST ? r_word[7:0] : r_word[15:8];
                if (out_ready) w_next = SECOND;
            end
            SECOND: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_src   = r_owner;
                out_byte  = LOW_FIRST ? r_word[15:8] : r_word[7:0];
                // w_grant already implies out_ready here, so a grant means back-to-back.
                if (out_ready) w_next = w_grant ? FIRST : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign busy = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word  <= 16'h0000;
            r_owner <= 1'b0;
            r_rr    <= 1'b0;
        end else if (w_grant) begin
            r_word  <= w_slice;
            r_owner <= w_gidx;
            r_rr    <= ~w_gidx;
        end
    end

endmodule

// File: tb/tb_union_byte_sched.sv
// Scoreboard bench: dut_a (low byte first) and dut_b (high byte first); a monitor
// pops expected {byte,src,last} entries on every output handshake.
module tb_union_byte_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  a_rv, a_rr, b_rv, b_rr;
    logic [31:0] a_rd, b_rd;
    logic        a_ov, a_src, a_last, a_or, a_busy;
    logic        b_ov, b_src, b_last, b_or, b_busy;
    logic [7:0]  a_ob, b_ob;

    union_byte_sched #(.LOW_FIRST(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_rv), .req_data(a_rd), .req_ready(a_rr),
        .out_valid(a_ov), .out_byte(a_ob), .out_src(a_src), .out_last(a_last),
        .out_ready(a_or), .busy(a_busy));

    union_byte_sched #(.LOW_FIRST(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_rv), .req_data(b_rd), .req_ready(b_rr),
        .out_valid(b_ov), .out_byte(b_ob), .out_src(b_src), .out_last(b_last),
        .out_ready(b_or), .busy(b_busy));

    typedef struct packed {
        logic [7:0] b;
        logic       s;
        logic       l;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;
    bit   auto_a = 1'b0;
    logic m_rr   = 1'b0;

    function automatic exp_t E(input logic [7:0] b, input logic s, input logic l);
        return {b, s, l};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every output handshake against the scoreboard queues.
    exp_t        pa, pb, x;
    logic        pa_hold = 1'b0, pb_hold = 1'b0;
    logic        g, eg;
    logic [15:0] sl;
    always @(negedge clk) begin
        if (rst_n) begin
            if (a_rr == 2'b11) chk("onehot_a", a_rr, 2'b01);
            if (pa_hold) chk("hold_a", {a_ov, a_ob, a_src, a_last}, {1'b1, pa});
            if (pb_hold) chk("hold_b", {b_ov, b_ob, b_src, b_last}, {1'b1, pb});
            if (a_ov && a_or) begin
                checks++;
                if (qa.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_a byte=%0h src=%0d last=%0d (none required)", a_ob, a_src, a_last);
                end else begin
                    x = qa.pop_front();
                    checks--;
                    chk("byte_a", {a_ob, a_src, a_last}, x);
                end
            end
            if (b_ov && b_or) begin
                checks++;
                if (qb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_b byte=%0h src=%0d last=%0d (none required)", b_ob, b_src, b_last);
                end else begin
                    x = qb.pop_front();
                    checks--;
                    chk("byte_b", {b_ob, b_src, b_last}, x);
                end
            end
            if (auto_a && (|(a_rv & a_rr))) begin
                g  = a_rr[1];
                eg = (a_rv == 2'b11) ? m_rr : a_rv[1];
                chk("grant_a", g, eg);
                m_rr = ~g;
                sl = g ? a_rd[31:16] : a_rd[15:0];
                qa.push_back(E(sl[7:0], g, 1'b0));
                qa.push_back(E(sl[15:8], g, 1'b1));
            end
            pa_hold = a_ov && !a_or;
            pa      = {a_ob, a_src, a_last};
            pb_hold = b_ov && !b_or;
            pb      = {b_ob, b_src, b_last};
        end else begin
            pa_hold = 1'b0;
            pb_hold = 1'b0;
        end
    end

    task automatic drain();
        int n = 0;
        while (n < 200 && !(qa.size() == 0 && qb.size() == 0 && !a_busy && !b_busy)) begin
            @(negedge clk);
            n++;
        end
        chk("drain", n < 200, 1);
    endtask

    // Holds req_valid=v until n words are accepted; counts idle cycles in between.
    task automatic send_a(input logic [1:0] v, input int n, output int gaps);
        int acc = 0;
        int t = 0;
        bit started = 1'b0;
        gaps = 0;
        @(posedge clk); #1;
        a_rv = v;
        while (acc < n && t < 200) begin
            @(negedge clk);
            t++;
            if (started && !a_busy) gaps++;
            if (|(a_rv & a_rr)) begin
                acc++;
                started = 1'b1;
            end
        end
        @(posedge clk); #1;
        a_rv = 2'b00;
        chk("send_count", acc, n);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int gaps;
        rst_n = 1'b0;
        a_rv = 2'b11; a_rd = 32'h0; a_or = 1'b1;
        b_rv = 2'b11; b_rd = 32'h0; b_or = 1'b1;

        // Reset state, with requests pending that must not be offered ready
        @(negedge clk);
        chk("rst_out_a", {a_ov, a_ob, a_src, a_last, a_busy}, 0);
        chk("rst_ready_a", a_rr, 2'b00);
        chk("rst_out_b", {b_ov, b_ob, b_src, b_last, b_busy}, 0);
        chk("rst_ready_b", b_rr, 2'b00);
        @(posedge clk); #1;
        rst_n = 1'b1; a_rv = 2'b00; b_rv = 2'b00;

        // Single word, low byte first
        qa.push_back(E(8'h5A, 1'b0, 1'b0));
        qa.push_back(E(8'hA5, 1'b0, 1'b1));
        @(posedge clk); #1;
        a_rv = 2'b01; a_rd = 32'h0000A55A;
        @(negedge clk);
        chk("t31_ready", a_rr, 2'b01);
        @(posedge clk); #1;
        a_rv = 2'b00;
        @(negedge clk);
        chk("t31_ready_off", a_rr, 2'b00);
        chk("t31_busy", a_busy, 1);
        drain();

        // Lone requester 1 for three words (pointer left at 1 by previous grant to 0)
        a_rd = {16'h3344, 16'h1122};
        repeat (3) begin
            qa.push_back(E(8'h44, 1'b1, 1'b0));
            qa.push_back(E(8'h33, 1'b1, 1'b1));
        end
        send_a(2'b10, 3, gaps);
        chk("t34_gaps", gaps, 0);

        // Both valid: requester 0 must come next, then strict alternation, no bubbles
        qa.push_back(E(8'h22, 1'b0, 1'b0)); qa.push_back(E(8'h11, 1'b0, 1'b1));
        qa.push_back(E(8'h44, 1'b1, 1'b0)); qa.push_back(E(8'h33, 1'b1, 1'b1));
        qa.push_back(E(8'h22, 1'b0, 1'b0)); qa.push_back(E(8'h11, 1'b0, 1'b1));
        qa.push_back(E(8'h44, 1'b1, 1'b0)); qa.push_back(E(8'h33, 1'b1, 1'b1));
        send_a(2'b11, 4, gaps);
        chk("t32_gaps", gaps, 0);
        drain();

        // High byte first with a 3-cycle stall in FIRST
        qb.push_back(E(8'hBE, 1'b1, 1'b0));
        qb.push_back(E(8'hEF, 1'b1, 1'b1));
        @(posedge clk); #1;
        b_rv = 2'b10; b_rd = {16'hBEEF, 16'h0000}; b_or = 1'b0;
        @(posedge clk); #1;
        b_rv = 2'b00;
        repeat (3) begin
            @(negedge clk);
            chk("t33_stall", {b_ov, b_ob, b_src, b_last}, {1'b1, 8'hBE, 1'b1, 1'b0});
        end
        @(posedge clk); #1;
        b_or = 1'b1;
        @(negedge clk);
        chk("t33_first", {b_ov, b_ob, b_src, b_last}, {1'b1, 8'hBE, 1'b1, 1'b0});
        @(negedge clk);
        chk("t33_second", {b_ov, b_ob, b_src, b_last}, {1'b1, 8'hEF, 1'b1, 1'b1});
        drain();

        // Reset in SECOND of 0xCAFE: high byte discarded, pointer back to 0
        qa.push_back(E(8'hFE, 1'b0, 1'b0));
        @(posedge clk); #1;
        a_rv = 2'b01; a_rd = 32'h0000CAFE;
        @(posedge clk); #1;
        a_rv = 2'b00;
        @(posedge clk); #1;
        chk("t35_in_second", {a_ov, a_ob, a_last}, {1'b1, 8'hCA, 1'b1});
        rst_n = 1'b0;
        #1;
        chk("t35_rst_out", {a_ov, a_ob, a_src, a_last, a_busy}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_rd = {16'h0304, 16'h0102};
        qa.push_back(E(8'h02, 1'b0, 1'b0));
        qa.push_back(E(8'h01, 1'b0, 1'b1));
        send_a(2'b11, 1, gaps);
        drain();

        // Random traffic with model-predicted grants; pointer now 1
        m_rr   = 1'b1;
        auto_a = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            a_rv = 2'($urandom_range(0, 3));
            a_rd = $urandom;
            a_or = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        a_rv = 2'b00; a_or = 1'b1;
        drain();
        auto_a = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
